// File: rtl/dmem_rsel_pkg.sv
// rtl/dmem_rsel_pkg.sv - shared load funct3 codes, memory map and region decode
package dmem_rsel_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    localparam int REGION_DMEM_BIT = 28;
    localparam int REGION_BIOS_BIT = 30;
    localparam int REGION_MMIO_BIT = 31;

    localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
    localparam logic [7:0] MMIO_UART_RX   = 8'h04;
    localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] MMIO_INST_CNT  = 8'h14;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_DMEM = 2'd1,
        RGN_BIOS = 2'd2,
        RGN_MMIO = 2'd3
    } region_e;

    // MMIO wins over BIOS, BIOS over DMEM, when several region bits are set
    function automatic region_e decode_region(input logic mmio_bit, input logic bios_bit,
                                              input logic dmem_bit);
        if (mmio_bit)      return RGN_MMIO;
        else if (bios_bit) return RGN_BIOS;
        else if (dmem_bit) return RGN_DMEM;
        else               return RGN_NONE;
    endfunction

endpackage

// File: rtl/dmem_rsel_if.sv
// rtl/dmem_rsel_if.sv - load request, memory return, UART and counter signals
interface dmem_rsel_if;
    logic        re;
    logic        stall;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_tx_ready;
    logic        inst_retire;
    logic        counter_reset;
    logic        uart_rx_ready;
    logic [31:0] load_data;
    logic        load_valid;

    modport master (
        output re, stall, funct3, addr, dmem_dout, bios_dout,
               uart_rx_valid, uart_rx_data, uart_tx_ready, inst_retire, counter_reset,
        input  uart_rx_ready, load_data, load_valid
    );

    modport slave (
        input  re, stall, funct3, addr, dmem_dout, bios_dout,
               uart_rx_valid, uart_rx_data, uart_tx_ready, inst_retire, counter_reset,
        output uart_rx_ready, load_data, load_valid
    );
endinterface

// File: rtl/dmem_rsel_load_extract.sv
// rtl/dmem_rsel_load_extract.sv - byte/half/word select with sign or zero extension
module dmem_rsel_load_extract
    import dmem_rsel_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[8*offset_i +: 8];
    assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            FNC_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            FNC_LBU: data_o = {24'b0, byte_sel};
            FNC_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            FNC_LHU: data_o = {16'b0, half_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/dmem_rsel.sv
// rtl/dmem_rsel.sv - load-side source select, MMIO counters and UART pop strobe
module dmem_rsel
    import dmem_rsel_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    dmem_rsel_if.slave  bus
);
    region_e                region_q, region_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             off_q, off_d;
    logic [31:0]            mmio_q, mmio_d;
    logic                   valid_q, valid_d;
    logic                   pop_q, pop_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   inst_q, inst_d;

    logic                   capture;
    region_e                rgn_req;
    logic [31:0]            mmio_rd;
    logic [31:0]            word_sel;
    logic                   unused_addr_bits;

    assign capture = bus.re & ~bus.stall;
    assign rgn_req = decode_region(bus.addr[REGION_MMIO_BIT], bus.addr[REGION_BIOS_BIT],
                                   bus.addr[REGION_DMEM_BIT]);
    assign unused_addr_bits = ^{bus.addr[29], bus.addr[27:6]};

    // MMIO word is sampled now so it lines up with the one-cycle BRAM read
    always_comb begin
        mmio_rd = 32'b0;
        case (bus.addr[5:2])
            MMIO_UART_CTRL[5:2]: mmio_rd = {30'b0, bus.uart_rx_valid, bus.uart_tx_ready};
            MMIO_UART_RX[5:2]:   mmio_rd = {24'b0, bus.uart_rx_data};
            MMIO_CYCLE_CNT[5:2]: mmio_rd = 32'(cycle_q);
            MMIO_INST_CNT[5:2]:  mmio_rd = 32'(inst_q);
            default:             mmio_rd = 32'b0;
        endcase
    end

    always_comb begin
        region_d = region_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        mmio_d   = mmio_q;
        valid_d  = valid_q;
        pop_d    = 1'b0;
        if (!bus.stall) valid_d = bus.re;
        if (capture) begin
            region_d = rgn_req;
            funct3_d = bus.funct3;
            off_d    = bus.addr[1:0];
            mmio_d   = mmio_rd;
            pop_d    = (rgn_req == RGN_MMIO) && (bus.addr[5:2] == MMIO_UART_RX[5:2])
                       && bus.uart_rx_valid;
        end
        cycle_d = bus.counter_reset ? '0 : cycle_q + CNT_WIDTH'(1);
        inst_d  = bus.counter_reset ? '0 : inst_q + CNT_WIDTH'(bus.inst_retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            region_q <= RGN_NONE;
            funct3_q <= 3'b0;
            off_q    <= 2'b0;
            mmio_q   <= 32'b0;
            valid_q  <= 1'b0;
            pop_q    <= 1'b0;
            cycle_q  <= '0;
            inst_q   <= '0;
        end else begin
            region_q <= region_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            mmio_q   <= mmio_d;
            valid_q  <= valid_d;
            pop_q    <= pop_d;
            cycle_q  <= cycle_d;
            inst_q   <= inst_d;
        end
    end

    always_comb begin
        word_sel = 32'b0;
        case (region_q)
            RGN_DMEM: word_sel = bus.dmem_dout;
            RGN_BIOS: word_sel = bus.bios_dout;
            RGN_MMIO: word_sel = mmio_q;
            default:  word_sel = 32'b0;
        endcase
    end

    dmem_rsel_load_extract u_extract (
        .word_i   (word_sel),
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .data_o   (bus.load_data)
    );

    assign bus.load_valid    = valid_q;
    assign bus.uart_rx_ready = pop_q;
endmodule

// File: tb/tb_dmem_rsel.sv
// tb/tb_dmem_rsel.sv - directed scoreboard bench for dmem_rsel
module tb_dmem_rsel;
    import dmem_rsel_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    dmem_rsel_if bus ();
    dmem_rsel_if bus_w ();

    dmem_rsel #(.CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    dmem_rsel #(.CNT_WIDTH(4))  dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    assign bus_w.re            = bus.re;
    assign bus_w.stall         = bus.stall;
    assign bus_w.funct3        = bus.funct3;
    assign bus_w.addr          = bus.addr;
    assign bus_w.dmem_dout     = bus.dmem_dout;
    assign bus_w.bios_dout     = bus.bios_dout;
    assign bus_w.uart_rx_valid = bus.uart_rx_valid;
    assign bus_w.uart_rx_data  = bus.uart_rx_data;
    assign bus_w.uart_tx_ready = bus.uart_tx_ready;
    assign bus_w.inst_retire   = bus.inst_retire;
    assign bus_w.counter_reset = bus.counter_reset;

    always #5 clk = ~clk;

    logic [31:0] m_cyc, m_ins;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 32'd0;
            m_ins <= 32'd0;
        end else if (bus.counter_reset) begin
            m_cyc <= 32'd0;
            m_ins <= 32'd0;
        end else begin
            m_cyc <= m_cyc + 32'd1;
            m_ins <= m_ins + {31'd0, bus.inst_retire};
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [31:0] wdata;
        logic        pop;
        bit          chk_w;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] f3);
        bus.re     = 1'b1;
        bus.stall  = 1'b0;
        bus.addr   = a;
        bus.funct3 = f3;
    endtask

    task automatic check_front(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, bus.load_data, e.data);
            chk({tag, "_valid"}, {31'd0, bus.load_valid}, 32'd1);
            chk({tag, "_pop"}, {31'd0, bus.uart_rx_ready}, {31'd0, e.pop});
            if (e.chk_w) chk({tag, "_w"}, bus_w.load_data, e.wdata);
        end
    endtask

    // sel: 0 = fixed expectation, 1 = cycle counter, 2 = instruction counter
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] ed, input logic ep, input int sel);
        exp_t e;
        @(negedge clk);
        issue(a, f3);
        e.data  = (sel == 1) ? m_cyc : (sel == 2) ? m_ins : ed;
        e.wdata = (sel == 1) ? {28'd0, m_cyc[3:0]} : {28'd0, m_ins[3:0]};
        e.pop   = ep;
        e.chk_w = (sel != 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_front(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        bus.re = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {31'd0, bus.load_valid}, 32'd0);
        chk({tag, "_pop"}, {31'd0, bus.uart_rx_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found;
        exp_t e;
        n_checks = 0;
        n_err    = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.re = 1'b0; bus.stall = 1'b0; bus.funct3 = 3'b0; bus.addr = 32'b0;
        bus.dmem_dout = 32'h80F17F02; bus.bios_dout = 32'h12345678;
        bus.uart_rx_valid = 1'b0; bus.uart_rx_data = 8'hA5; bus.uart_tx_ready = 1'b1;
        bus.inst_retire = 1'b0; bus.counter_reset = 1'b0;
        #2;
        chk("rst_data", bus.load_data, 32'd0);
        chk("rst_valid", {31'd0, bus.load_valid}, 32'd0);
        chk("rst_pop", {31'd0, bus.uart_rx_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_load("lb3",   32'h10000003, FNC_LB,  32'hFFFFFF80, 1'b0, 0);
        do_load("lbu2",  32'h10000002, FNC_LBU, 32'h000000F1, 1'b0, 0);
        do_load("lh2",   32'h10000002, FNC_LH,  32'hFFFF80F1, 1'b0, 0);
        do_load("lhu0",  32'h10000000, FNC_LHU, 32'h00007F02, 1'b0, 0);
        do_load("lw",    32'h10000000, FNC_LW,  32'h80F17F02, 1'b0, 0);
        do_load("lh1",   32'h10000001, FNC_LH,  32'h00007F02, 1'b0, 0);
        do_load("f3und", 32'h10000000, 3'b011,  32'h80F17F02, 1'b0, 0);
        do_load("bios",  32'h40000000, FNC_LW,  32'h12345678, 1'b0, 0);
        do_load("prio",  32'h50000000, FNC_LW,  32'h12345678, 1'b0, 0);
        do_load("unmap", 32'h00000004, FNC_LW,  32'h00000000, 1'b0, 0);
        idle("idle0");

        bus.uart_rx_valid = 1'b1;
        do_load("rx0",   32'h80000004, FNC_LW, 32'h000000A5, 1'b1, 0);
        do_load("rx1",   32'h80000004, FNC_LW, 32'h000000A5, 1'b1, 0);
        do_load("stat",  32'h80000000, FNC_LW, 32'h00000003, 1'b0, 0);
        do_load("mm08",  32'h80000008, FNC_LW, 32'h00000000, 1'b0, 0);
        bus.uart_rx_valid = 1'b0;
        do_load("rxnv",  32'h80000004, FNC_LW, 32'h000000A5, 1'b0, 0);
        do_load("statnv",32'h80000000, FNC_LW, 32'h00000001, 1'b0, 0);
        idle("idle1");

        bus.uart_rx_valid = 1'b1;
        @(negedge clk);
        issue(32'h80000004, FNC_LW);
        bus.stall = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_valid", {31'd0, bus.load_valid}, 32'd0);
        chk("stall_pop", {31'd0, bus.uart_rx_ready}, 32'd0);
        @(negedge clk);
        bus.stall = 1'b0;
        bus.re    = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.inst_retire = i[0];
        end
        @(negedge clk);
        bus.inst_retire = 1'b0;
        do_load("cyc", 32'h80000010, FNC_LW, 32'd0, 1'b0, 1);
        do_load("ins", 32'h80000014, FNC_LW, 32'd0, 1'b0, 2);

        @(negedge clk);
        bus.re = 1'b0;
        bus.counter_reset = 1'b1;
        bus.inst_retire   = 1'b1;
        @(negedge clk);
        bus.counter_reset = 1'b0;
        bus.inst_retire   = 1'b0;
        issue(32'h80000014, FNC_LW);
        e.data = 32'd0; e.wdata = 32'd0; e.pop = 1'b0; e.chk_w = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_front("ins_clr");
        do_load("cyc_clr", 32'h80000010, FNC_LW, 32'd0, 1'b0, 1);

        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_cyc[3:0] == 4'hE) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap_sync", {31'd0, found}, 32'd1);
        do_load("wrap_f", 32'h80000010, FNC_LW, 32'd0, 1'b0, 1);
        do_load("wrap_0", 32'h80000010, FNC_LW, 32'd0, 1'b0, 1);

        @(negedge clk);
        bus.uart_rx_valid = 1'b1;
        issue(32'h80000004, FNC_LW);
        @(posedge clk);
        #1;
        chk("prerst_pop", {31'd0, bus.uart_rx_ready}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_data", bus.load_data, 32'd0);
        chk("midrst_valid", {31'd0, bus.load_valid}, 32'd0);
        chk("midrst_pop", {31'd0, bus.uart_rx_ready}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        bus.re = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_pop0", {31'd0, bus.uart_rx_ready}, 32'd0);
        chk("postrst_valid", {31'd0, bus.load_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("postrst_pop1", {31'd0, bus.uart_rx_ready}, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_rsel.md
# dmem_rsel

Load-side data path for the RISC-V core; the read counterpart of the store write-select logic. Registers the load's address, funct3 and source select in the execute stage. In the following cycle it selects among data memory, BIOS memory and memory-mapped I/O, then aligns and sign- or zero-extends the result for writeback. Owns the MMIO cycle and retired-instruction counters and issues the UART receive-FIFO pop handshake.

## Interface
Parameters:
- CNT_WIDTH, 32, width of cycle and instruction counters (reads zero-extend to 32 bits)

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- re  input  1  load instruction in execute stage this cycle
- stall  input  1  pipeline stall; holds all load-path registers
- funct3  input  3  load funct3 (LB/LH/LW/LBU/LHU)
- addr  input  32  load effective address (also drives BRAM read ports)
- dmem_dout  input  32  data memory read data, one cycle after addr
- bios_dout  input  32  BIOS memory read data, one cycle after addr
- uart_rx_valid  input  1  UART receive FIFO has a byte
- uart_rx_data  input  8  UART receive FIFO head byte
- uart_tx_ready  input  1  UART transmitter can accept a byte
- inst_retire  input  1  one instruction retired this cycle
- counter_reset  input  1  clear both counters (store to 0x80000018)
- uart_rx_ready  output  1  single-cycle pop strobe to UART receive FIFO
- load_data  output  32  aligned, extended load result for writeback
- load_valid  output  1  load_data corresponds to a load issued last cycle

## Operation
- Region select from addr: addr[31]=1 is MMIO; addr[30]=1 is BIOS; addr[28]=1 is DMEM; otherwise unmapped.
- Priority is MMIO > BIOS > DMEM. Unmapped regions read as 0.
- MMIO read map (addr[5:2]):
  - 0x80000000: {30'b0, uart_rx_valid, uart_tx_ready}
  - 0x80000004: {24'b0, uart_rx_data}
  - 0x80000010: cycle counter
  - 0x80000014: instruction counter
  - Other offsets read 0.
- MMIO word is sampled into a register at the request cycle, so it is aligned with the BRAM read latency.
- Extraction by registered funct3 and addr[1:0]:
  - LB/LBU: byte addr[1:0].
  - LH/LHU: halfword addr[1]; addr[0] is ignored.
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 returns the full word.
- Cycle counter increments every cycle, not gated by stall.
- Instruction counter increments when inst_retire=1.
- Both counters wrap at 2^CNT_WIDTH to 0.
- counter_reset clears both counters next edge and has priority over increment in the same cycle.
- UART pop: a non-stalled load to 0x80000004 with uart_rx_valid=1 at the request cycle produces uart_rx_ready=1 for exactly the next cycle.
- No pop is issued if uart_rx_valid=0; the load returns stale head data zero-extended.

## Timing
- Request at cycle N (re=1, stall=0). load_data and load_valid=1 appear in cycle N+1, combinational from the N+1 registers and BRAM dout.
- stall=1 at N: registers hold their previous contents; no new request is captured and no pop is issued.
- load_valid falls at N+2 unless a new request is captured at N+1.
- Back-to-back loads are supported at one per cycle.
- Two consecutive reads of 0x80000004 produce two pops on consecutive cycles, provided uart_rx_valid was high at each request cycle.
- Reset values:
  - load_data=0, load_valid=0, uart_rx_ready=0
  - both counters 0
  - registered region select = unmapped
- Reset asserted mid-load: the in-flight load is discarded and no pop is issued after reset deassertion.

## Structure
- Opcode.vh: FNC_LB/LH/LW/LBU/LHU constants (existing).
- Shared memory-map header: MMIO offsets 0x00, 0x04, 0x10, 0x14, 0x18 and region bit positions 28/30/31. The store-side write select uses the same header.
- One sub-module, load_extract: combinational byte/half/word select and extension from (word, offset[1:0], funct3).
- Top level holds the request registers, MMIO read mux, counters and pop strobe.

## Test plan
- DMEM word 0x80F17F02 at 0x10000000: LB at offset 3 -> 0xFFFFFF80; LBU at offset 2 -> 0x000000F1; LH at offset 2 -> 0xFFFF80F1; LHU at offset 0 -> 0x00007F02; LW -> 0x80F17F02.
- BIOS and DMEM both driven: load 0x40000000 returns bios_dout; load 0x00000004 returns 0; load_valid=1 one cycle after each request.
- uart_rx_valid=1, uart_rx_data=0xA5: LW 0x80000004 -> load_data=0x000000A5 and uart_rx_ready pulses once at N+1. Repeat with uart_rx_valid=0 -> no pulse. Repeat with stall=1 -> no pulse and no capture.
- Run 100 cycles with inst_retire toggling every other cycle: reads of 0x80000010/0x80000014 return exact counts. counter_reset and inst_retire asserted together -> instruction counter reads 0 next cycle. Preload cycle counter to 0xFFFFFFFF -> wraps to 0.
- Assert rst asynchronously between a request of 0x80000004 and its result -> all outputs 0 immediately and no uart_rx_ready afterward.
